// File: rtl/simd_vec_lane_packer.sv
// rtl/simd_vec_lane_packer.sv - packs a scalar (a,b) element stream into framed NUM_LANES-wide beats
// Output side is valid-only: the downstream MAC never stalls.
module simd_vec_lane_packer #(
   parameter int NUM_LANES    = 4,
   parameter int ELEM_W       = 16,
   parameter int MAX_NUM_ELEM = 64,
   parameter int LEN_W        = $clog2(MAX_NUM_ELEM + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cmd_valid_i,
   output logic                             cmd_ready_o,
   input  logic [LEN_W-1:0]                 cmd_len_i,
   input  logic                             elem_valid_i,
   output logic                             elem_ready_o,
   input  logic [ELEM_W-1:0]                elem_a_i,
   input  logic [ELEM_W-1:0]                elem_b_i,
   output logic                             valid_o,
   output logic                             start_o,
   output logic                             last_o,
   output logic [NUM_LANES-1:0][ELEM_W-1:0] A_o,
   output logic [NUM_LANES-1:0][ELEM_W-1:0] B_o,
   output logic                             len_err_o,
   output logic                             busy_o
);

   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t                          r_state;
   logic [LEN_W-1:0]                r_remaining;
   logic [LANE_W-1:0]               r_lane_idx;
   logic                            r_first;
   logic [NUM_LANES-1:0][ELEM_W-1:0] r_buf_a;
   logic [NUM_LANES-1:0][ELEM_W-1:0] r_buf_b;
   logic [NUM_LANES-1:0][ELEM_W-1:0] r_a;
   logic [NUM_LANES-1:0][ELEM_W-1:0] r_b;
   logic                            r_valid;
   logic                            r_start;
   logic                            r_last;
   logic                            r_len_err;

   logic                            w_cmd_hs;
   logic                            w_elem_hs;
   logic                            w_len_ok;
   logic                            w_final;
   logic                            w_beat_done;
   logic [NUM_LANES-1:0][ELEM_W-1:0] w_next_a;
   logic [NUM_LANES-1:0][ELEM_W-1:0] w_next_b;

   assign cmd_ready_o  = (r_state == IDLE);
   assign elem_ready_o = (r_state == COLLECT);
   assign busy_o       = (r_state == COLLECT);

   assign w_cmd_hs    = cmd_valid_i && cmd_ready_o;
   assign w_elem_hs   = elem_valid_i && elem_ready_o;
   assign w_len_ok    = (cmd_len_i != '0) && (cmd_len_i <= LEN_W'(MAX_NUM_ELEM));
   assign w_final     = (r_remaining == LEN_W'(1));
   assign w_beat_done = w_final || (r_lane_idx == LANE_W'(NUM_LANES - 1));

   // Buffer is cleared after every beat, so lanes above lane_idx are already zero.
   always_comb begin
      w_next_a = r_buf_a;
      w_next_b = r_buf_b;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (r_lane_idx == LANE_W'(i)) begin
            w_next_a[i] = elem_a_i;
            w_next_b[i] = elem_b_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_remaining <= '0;
         r_lane_idx  <= '0;
         r_first     <= 1'b0;
         r_buf_a     <= '0;
         r_buf_b     <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_valid     <= 1'b0;
         r_start     <= 1'b0;
         r_last      <= 1'b0;
         r_len_err   <= 1'b0;
      end else begin
         r_valid   <= 1'b0;
         r_start   <= 1'b0;
         r_last    <= 1'b0;
         r_len_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_cmd_hs) begin
                  if (w_len_ok) begin
                     r_remaining <= cmd_len_i;
                     r_lane_idx  <= '0;
                     r_first     <= 1'b1;
                     r_buf_a     <= '0;
                     r_buf_b     <= '0;
                     r_state     <= COLLECT;
                  end else begin
                     r_len_err <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (w_elem_hs) begin
                  r_remaining <= r_remaining - LEN_W'(1);
                  if (w_beat_done) begin
                     r_valid    <= 1'b1;
                     r_start    <= r_first;
                     r_last     <= w_final;
                     r_a        <= w_next_a;
                     r_b        <= w_next_b;
                     r_first    <= 1'b0;
                     r_lane_idx <= '0;
                     r_buf_a    <= '0;
                     r_buf_b    <= '0;
                  end else begin
                     r_lane_idx <= r_lane_idx + LANE_W'(1);
                     r_buf_a    <= w_next_a;
                     r_buf_b    <= w_next_b;
                  end
                  if (w_final) begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign valid_o   = r_valid;
   assign start_o   = r_start;
   assign last_o    = r_last;
   assign A_o       = r_a;
   assign B_o       = r_b;
   assign len_err_o = r_len_err;

endmodule

// File: tb/tb_simd_vec_lane_packer.sv
// tb/tb_simd_vec_lane_packer.sv - self-checking bench for simd_vec_lane_packer
// Expected beats are rebuilt from the element list by lane arithmetic; a dot product stands in for the MAC.
module tb_simd_vec_lane_packer;

   localparam int N    = 4;
   localparam int W    = 16;
   localparam int MAXE = 64;
   localparam int LW   = $clog2(MAXE + 1);

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   cmd_valid_i = 1'b0;
   logic                   cmd_ready_o;
   logic [LW-1:0]          cmd_len_i = '0;
   logic                   elem_valid_i = 1'b0;
   logic                   elem_ready_o;
   logic [W-1:0]           elem_a_i = '0;
   logic [W-1:0]           elem_b_i = '0;
   logic                   valid_o, start_o, last_o, len_err_o, busy_o;
   logic [N-1:0][W-1:0]    A_o, B_o;

   simd_vec_lane_packer #(.NUM_LANES(N), .ELEM_W(W), .MAX_NUM_ELEM(MAXE)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
      .elem_valid_i(elem_valid_i), .elem_ready_o(elem_ready_o),
      .elem_a_i(elem_a_i), .elem_b_i(elem_b_i),
      .valid_o(valid_o), .start_o(start_o), .last_o(last_o),
      .A_o(A_o), .B_o(B_o), .len_err_o(len_err_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0][W-1:0] a;
      logic [N-1:0][W-1:0] b;
      logic                s;
      logic                l;
      int                  c;
   } beat_t;

   typedef struct {
      int             len;
      logic [W-1:0]   a[8];
      logic [W-1:0]   b[8];
      int             beats;
      int             errs;
      logic [N*W-1:0] fa;
      logic [N*W-1:0] la;
      logic [N*W-1:0] lb;
   } vec_t;

   int           n_cmp = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           err_pulses = 0;
   beat_t        obs[$];
   beat_t        mon_bt;
   logic [W-1:0] g_a[$];
   logic [W-1:0] g_b[$];
   int           g_hs[$];
   vec_t         tbl[5];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (valid_o) begin
            mon_bt.a = A_o;
            mon_bt.b = B_o;
            mon_bt.s = start_o;
            mon_bt.l = last_o;
            mon_bt.c = cyc;
            obs.push_back(mon_bt);
         end
         if (len_err_o) err_pulses++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_cmd(input int len);
      int t = 0;
      cmd_len_i   = LW'(len);
      cmd_valid_i = 1'b1;
      @(negedge clk);
      while (!cmd_ready_o && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (!cmd_ready_o) check("cmd_ready_timeout", 0, 1);
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
   endtask

   // A handshake presented during cycle K is recorded as K; its beat must be visible in cycle K+1.
   task automatic send_elems(input int cnt, input int maxgap);
      int t;
      for (int i = 0; i < cnt; i++) begin
         repeat ($urandom_range(maxgap, 0)) begin
            @(posedge clk); #1;
         end
         elem_a_i     = g_a[i];
         elem_b_i     = g_b[i];
         elem_valid_i = 1'b1;
         t = 0;
         @(negedge clk);
         while (!elem_ready_o && t < 50) begin
            t++;
            @(negedge clk);
         end
         if (!elem_ready_o) begin
            check("elem_ready_timeout", 0, 1);
            elem_valid_i = 1'b0;
            return;
         end
         g_hs.push_back(cyc);
         @(posedge clk); #1;
         elem_valid_i = 1'b0;
      end
   endtask

   task automatic check_vec(input string nm, input int len);
      int                  nb;
      int                  idx;
      int                  li;
      logic [N-1:0][W-1:0] ea, eb;
      longint              dm, dg;
      nb = (len + N - 1) / N;
      dm = 0;
      dg = 0;
      check({nm, "_beats"}, obs.size(), nb);
      if (obs.size() == nb) begin
         for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < N; j++) begin
               idx   = k * N + j;
               ea[j] = (idx < len) ? g_a[idx] : '0;
               eb[j] = (idx < len) ? g_b[idx] : '0;
               dm   += $signed(obs[k].a[j]) * $signed(obs[k].b[j]);
            end
            li = ((k + 1) * N < len) ? (k + 1) * N - 1 : len - 1;
            check($sformatf("%s_A%0d", nm, k), obs[k].a, ea);
            check($sformatf("%s_B%0d", nm, k), obs[k].b, eb);
            check($sformatf("%s_start%0d", nm, k), obs[k].s, (k == 0));
            check($sformatf("%s_last%0d", nm, k), obs[k].l, (k == nb - 1));
            check($sformatf("%s_lat%0d", nm, k), obs[k].c, g_hs[li] + 1);
         end
         for (int i = 0; i < len; i++) dg += $signed(g_a[i]) * $signed(g_b[i]);
         check({nm, "_dot"}, dm, dg);
      end
      obs.delete();
   endtask

   task automatic load_random(input int len);
      g_a.delete(); g_b.delete(); g_hs.delete();
      for (int i = 0; i < len; i++) begin
         g_a.push_back(W'($urandom));
         g_b.push_back(W'($urandom));
      end
   endtask

   initial begin
      tbl[0].len = 4; tbl[0].beats = 1; tbl[0].errs = 0;
      tbl[1].len = 6; tbl[1].beats = 2; tbl[1].errs = 0;
      tbl[2].len = 1; tbl[2].beats = 1; tbl[2].errs = 0;
      tbl[3].len = 0; tbl[3].beats = 0; tbl[3].errs = 1;
      tbl[4].len = 65; tbl[4].beats = 0; tbl[4].errs = 1;
      for (int i = 0; i < 8; i++) begin
         for (int v = 0; v < 5; v++) begin
            tbl[v].a[i] = '0;
            tbl[v].b[i] = '0;
         end
         tbl[0].a[i] = W'(i + 1);
         tbl[0].b[i] = W'(10 * (i + 1));
         tbl[1].a[i] = W'(i + 1);
         tbl[1].b[i] = W'(-(i + 1));
      end
      tbl[2].a[0] = 16'h8000;
      tbl[2].b[0] = 16'h7FFF;
      tbl[0].fa = {16'd4, 16'd3, 16'd2, 16'd1};
      tbl[0].la = {16'd4, 16'd3, 16'd2, 16'd1};
      tbl[0].lb = {16'd40, 16'd30, 16'd20, 16'd10};
      tbl[1].fa = {16'd4, 16'd3, 16'd2, 16'd1};
      tbl[1].la = {16'd0, 16'd0, 16'd6, 16'd5};
      tbl[1].lb = {16'd0, 16'd0, 16'hFFFA, 16'hFFFB};
      tbl[2].fa = {48'd0, 16'h8000};
      tbl[2].la = {48'd0, 16'h8000};
      tbl[2].lb = {48'd0, 16'h7FFF};
      for (int v = 3; v < 5; v++) begin
         tbl[v].fa = '0; tbl[v].la = '0; tbl[v].lb = '0;
      end

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", valid_o, 0);
      check("rst_start_last", {start_o, last_o}, 0);
      check("rst_len_err", len_err_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_A", A_o, 0);
      check("rst_B", B_o, 0);
      check("rst_cmd_ready", cmd_ready_o, 1);
      check("rst_elem_ready", elem_ready_o, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 5; v++) begin
         g_a.delete(); g_b.delete(); g_hs.delete();
         err_pulses = 0;
         if (tbl[v].errs == 0) begin
            for (int i = 0; i < tbl[v].len; i++) begin
               g_a.push_back(tbl[v].a[i]);
               g_b.push_back(tbl[v].b[i]);
            end
         end
         send_cmd(tbl[v].len);
         if (tbl[v].errs == 0) begin
            send_elems(tbl[v].len, 0);
         end else begin
            repeat (4) begin
               @(negedge clk);
               check($sformatf("t%0d_elem_ready_idle", v), elem_ready_o, 0);
            end
         end
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("t%0d_len_err", v), err_pulses, tbl[v].errs);
         check($sformatf("t%0d_cmd_ready", v), cmd_ready_o, 1);
         if (tbl[v].errs != 0) begin
            check($sformatf("t%0d_no_beat", v), obs.size(), 0);
            obs.delete();
         end else begin
            if (obs.size() == tbl[v].beats) begin
               check($sformatf("t%0d_firstA", v), obs[0].a, tbl[v].fa);
               check($sformatf("t%0d_lastA", v), obs[tbl[v].beats - 1].a, tbl[v].la);
               check($sformatf("t%0d_lastB", v), obs[tbl[v].beats - 1].b, tbl[v].lb);
            end
            check_vec($sformatf("t%0d", v), tbl[v].len);
         end
      end

      // Full-length vector with gaps, then a handful of random lengths.
      for (int r = 0; r < 8; r++) begin
         int len;
         len = (r == 0) ? MAXE : int'($urandom_range(MAXE, 1));
         load_random(len);
         err_pulses = 0;
         send_cmd(len);
         send_elems(len, 3);
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("r%0d_no_err", r), err_pulses, 0);
         check_vec($sformatf("r%0d_len%0d", r, len), len);
      end

      // Reset mid-vector: one beat from the first four elements, then nothing.
      load_random(8);
      send_cmd(8);
      send_elems(5, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", valid_o, 0);
      check("mid_rst_A", A_o, 0);
      check("mid_rst_busy", busy_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid_rst_cmd_ready", cmd_ready_o, 1);
      check("mid_rst_beats", obs.size(), 1);
      if (obs.size() == 1) begin
         check("mid_rst_beatA", obs[0].a, {g_a[3], g_a[2], g_a[1], g_a[0]});
         check("mid_rst_beat_sl", {obs[0].s, obs[0].l}, 2'b10);
      end
      obs.delete();
      load_random(2);
      send_cmd(2);
      send_elems(2, 1);
      repeat (3) @(posedge clk);
      #1;
      check_vec("post_rst", 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/simd_vec_lane_packer.md
Name: simd_vec_lane_packer

Overview:
Upstream feeder for simd_vector_mac. Accepts a vector-length command, then a scalar stream of (a, b) element pairs, one pair per handshake. Packs the pairs into NUM_LANES-wide beats with start/last framing and zero-padded tail lanes, which drive the MAC's valid_i/start_i/last_i/A/B directly. The MAC applies no backpressure, so the output side is valid-only.

Parameters:
NUM_LANES, 4, lanes per output beat
ELEM_W, 16, signed element width
MAX_NUM_ELEM, 64, maximum legal vector length in elements
LEN_W, $clog2(MAX_NUM_ELEM+1), command length field width

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  vector command valid
cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o
cmd_len_i  in  LEN_W  vector length in elements
elem_valid_i  in  1  element pair valid
elem_ready_o  out  1  element pair accepted when elem_valid_i && elem_ready_o
elem_a_i  in  ELEM_W  signed A element
elem_b_i  in  ELEM_W  signed B element
valid_o  out  1  beat valid, to the MAC's valid_i
start_o  out  1  first beat of the vector, to the MAC's start_i
last_o  out  1  final beat of the vector, to the MAC's last_i
A_o  out  [NUM_LANES-1:0][ELEM_W-1:0]  packed A lanes
B_o  out  [NUM_LANES-1:0][ELEM_W-1:0]  packed B lanes
len_err_o  out  1  one-cycle pulse: illegal command length
busy_o  out  1  high while in COLLECT

Behaviour:
- Reset (async assert, sync release): state=IDLE. valid_o, start_o, last_o, len_err_o and busy_o are 0. A_o, B_o, the lane buffer, lane_idx and remaining are all 0.
- FSM states are IDLE and COLLECT.
- cmd_ready_o = (state==IDLE); elem_ready_o = (state==COLLECT). Both are combinational from state only.
- IDLE, command handshake with 1 <= cmd_len_i <= MAX_NUM_ELEM:
  - remaining=cmd_len_i, lane_idx=0, first=1, buffer cleared;
  - next state is COLLECT.
- IDLE, command handshake with cmd_len_i==0 or cmd_len_i>MAX_NUM_ELEM:
  - command consumed; len_err_o=1 for the next cycle only;
  - state stays IDLE; no beat is produced.
- IDLE: elements are ignored (ready=0).
- COLLECT, on each element handshake:
  - buffer lane lane_idx gets elem_a_i / elem_b_i;
  - remaining decrements; lane_idx increments.
- Beat emission. When the accepted element fills lane NUM_LANES-1, or remaining==1 (final element):
  - next cycle: valid_o=1; A_o/B_o = buffer including the new element, with lanes above the written index forced to 0;
  - start_o=first; last_o=(remaining==1);
  - first clears; lane_idx=0; buffer cleared.
- Latency: valid_o is asserted exactly 1 cycle after the handshake of the beat-completing element.
- valid_o/start_o/last_o are single-cycle pulses. A_o/B_o hold their value until the next beat, or reset to 0.
- Lane order: lane 0 (bits ELEM_W-1:0) holds the earliest element of the beat.
- Final element accepted: next state is IDLE. A new command can therefore be accepted no earlier than the cycle after the final element.
- Beat count per vector = ceil(len/NUM_LANES). The single-beat case has start_o=last_o=1.
- Gaps in elem_valid_i are allowed; partial beats are held indefinitely.
- The upstream source must hold element and command fields stable while valid is high and ready is low. The block does not check this.
- Elements pass through unmodified, with no arithmetic or sign handling.
- Reset mid-vector:
  - the partial buffer and the vector are discarded; no valid_o is emitted;
  - the post-reset state is IDLE.
- A beat already registered on outputs when rst asserts is cleared immediately (async).

Test Plan:
- len=4, pairs a=1,2,3,4 / b=10,20,30,40, no gaps -> one beat 1 cycle after the 4th handshake: start_o=last_o=1, A_o lanes[3:0]={4,3,2,1}, B_o={40,30,20,10}; cmd_ready_o returns high.
- len=6, a=1..6, b=-1..-6 -> beat 1: start=1, last=0, A={4,3,2,1}. Beat 2: start=0, last=1, A={0,0,6,5}, B={0,0,-6,-5}.
- len=1, a=-32768, b=32767 -> one beat: start=last=1, A={0,0,0,-32768}, B={0,0,0,32767}.
- len=0, then len=65 -> each gives a single len_err_o pulse, no valid_o, and elem_ready_o stays 0.
- len=64, elements with random 0-3 cycle gaps -> exactly 16 beats, start only on the first and last only on the 16th. Feeding the simd_vector_mac reference model, the sum equals the golden dot product.
- len=8, assert rst after 5 elements -> no further valid_o. After release: IDLE, cmd_ready_o=1, and a following len=2 vector produces one correct beat with start=last=1.
